cache_sa_ctrl: RTL

Parametrised set-associative cache tag/statistics engine, the next generation of cache_top: configurable sets, ways, block size and address width, with a valid/ready request handshake.
- Models tags, valid and dirty state only; holds no data.
- Sits between a trace/address source and the statistics readout.
- Supports LRU/FIFO replacement and write-back/write-through policies, and counts memory traffic.

---
 rtl/cache_sa_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cache_sa_ctrl.sv
// Set-associative cache tag/state engine: tags, valid, dirty and replacement state per set,
// one access per two cycles, with access and next-level traffic statistics.
module cache_sa_ctrl #(
  parameter int ADDR_W      = 48,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_SETS    = 256,
  parameter int NUM_WAYS    = 4,
  parameter int CNT_W       = 32,
  localparam int OFF_W = $clog2(BLOCK_BYTES),
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS),
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_policy,
  input  logic              replace_policy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              resp_evict_dirty,
  output logic [TAG_W-1:0]  curr_tag,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_hits,
  output logic [CNT_W-1:0]  num_misses,
  output logic [CNT_W-1:0]  num_mem_reads,
  output logic [CNT_W-1:0]  num_mem_writes
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOOKUP = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  state_t state_q, state_d;
  logic                      we_q, wp_q, rp_q;
  logic [ADDR_W-OFF_W-1:0]   blk_q;
  logic [TAG_W-1:0]          curr_tag_q;
  logic                      resp_valid_q, resp_hit_q, resp_evd_q;
  logic [WAY_W-1:0]          resp_way_q;
  logic [CNT_W-1:0]          rd_q, wr_q, hit_q, miss_q, mrd_q, mwr_q;
  logic [TAG_W-1:0]          tag_q   [NUM_SETS][NUM_WAYS];
  logic                      valid_q [NUM_SETS][NUM_WAYS];
  logic                      dirty_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]          age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]          ptr_q   [NUM_SETS];

  logic [IDX_W-1:0] set_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s, inv_found_s, alloc_s, touch_s, evict_dirty_s, mem_wr_s, accept_s;
  logic [WAY_W-1:0] hit_way_s, inv_way_s, lru_way_s, victim_s, touch_way_s, resp_way_s;
  logic [WAY_W-1:0] new_age_s [NUM_WAYS];
  logic             unused_off_s;

  assign unused_off_s = ^req_addr[OFF_W-1:0];
  assign accept_s     = (state_q == IDLE) && req_valid;

  // Lookup, victim choice and next replacement state for the captured request.
  always_comb begin
    state_d     = state_q;
    set_s       = blk_q[IDX_W-1:0];
    tag_s       = blk_q[ADDR_W-OFF_W-1:IDX_W];
    hit_s       = 1'b0;
    hit_way_s   = '0;
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    lru_way_s   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_s][w] && (tag_q[set_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end
      if (!valid_q[set_s][w] && !inv_found_s) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end
      if (age_q[set_s][w] == WAY_W'(NUM_WAYS - 1)) begin
        lru_way_s = WAY_W'(w);
      end
    end
    if (inv_found_s) victim_s = inv_way_s;
    else if (rp_q)   victim_s = ptr_q[set_s];
    else             victim_s = lru_way_s;
    // A write-through write miss bypasses the cache entirely.
    alloc_s       = !hit_s && !(we_q && wp_q);
    touch_s       = hit_s || alloc_s;
    touch_way_s   = hit_s ? hit_way_s : victim_s;
    resp_way_s    = touch_s ? touch_way_s : '0;
    evict_dirty_s = alloc_s && valid_q[set_s][victim_s] && dirty_q[set_s][victim_s];
    mem_wr_s      = evict_dirty_s || (we_q && wp_q);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == touch_way_s)                          new_age_s[w] = '0;
      else if (age_q[set_s][w] < age_q[set_s][touch_way_s]) new_age_s[w] = age_q[set_s][w] + 1'b1;
      else                                                   new_age_s[w] = age_q[set_s][w];
    end
    case (state_q)
      IDLE:    state_d = req_valid ? LOOKUP : IDLE;
      LOOKUP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, request capture, responses, statistics and per-set line state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      wp_q         <= 1'b0;
      rp_q         <= 1'b0;
      blk_q        <= '0;
      curr_tag_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_evd_q   <= 1'b0;
      resp_way_q   <= '0;
      {rd_q, wr_q, hit_q, miss_q, mrd_q, mwr_q} <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (accept_s) begin
        we_q       <= req_we;
        wp_q       <= write_policy;
        rp_q       <= replace_policy;
        blk_q      <= req_addr[ADDR_W-1:OFF_W];
        curr_tag_q <= req_addr[ADDR_W-1 -: TAG_W];
      end
      if (state_q == LOOKUP) begin
        resp_valid_q <= 1'b1;
        resp_hit_q   <= hit_s;
        resp_way_q   <= resp_way_s;
        resp_evd_q   <= evict_dirty_s;
        rd_q   <= sat_inc(rd_q, !we_q);
        wr_q   <= sat_inc(wr_q, we_q);
        hit_q  <= sat_inc(hit_q, hit_s);
        miss_q <= sat_inc(miss_q, !hit_s);
        mrd_q  <= sat_inc(mrd_q, alloc_s);
        mwr_q  <= sat_inc(mwr_q, mem_wr_s);
        if (touch_s) begin
          for (int w = 0; w < NUM_WAYS; w++) age_q[set_s][w] <= new_age_s[w];
        end
        if (alloc_s) begin
          valid_q[set_s][victim_s] <= 1'b1;
          dirty_q[set_s][victim_s] <= we_q;
          if (!inv_found_s && rp_q) ptr_q[set_s] <= ptr_q[set_s] + 1'b1;
        end else if (hit_s && we_q && !wp_q) begin
          dirty_q[set_s][hit_way_s] <= 1'b1;
        end
      end
    end
  end

  // Tag storage needs no reset: valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (reset && (state_q == LOOKUP) && alloc_s) begin
      tag_q[set_s][victim_s] <= tag_s;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_way         = resp_way_q;
  assign resp_evict_dirty = resp_evd_q;
  assign curr_tag         = curr_tag_q;
  assign num_reads        = rd_q;
  assign num_writes       = wr_q;
  assign num_hits         = hit_q;
  assign num_misses       = miss_q;
  assign num_mem_reads    = mrd_q;
  assign num_mem_writes   = mwr_q;

endmodule
